// File: rtl/march_pkg.sv
// Shared definitions for the March C- BIST controller: FSM states,
// background words and the per-element descriptor table.
package march_pkg;

  // FSM states; the march elements are numbered consecutively so the
  // descriptor table can be indexed directly by state.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_M0   = 4'd1,
    ST_M1   = 4'd2,
    ST_M2   = 4'd3,
    ST_M3   = 4'd4,
    ST_M4   = 4'd5,
    ST_M5   = 4'd6,
    ST_DONE = 4'd7
  } state_t;

  localparam logic [7:0] BG_ZERO = 8'h00;
  localparam logic [7:0] BG_ONE  = 8'hFF;

  // Element descriptor: address direction, which operations it issues,
  // background expected on the read and background written.
  typedef struct packed {
    logic       dir_down;
    logic       has_rd;
    logic       has_wr;
    logic [7:0] rd_bg;
    logic [7:0] wr_bg;
  } desc_t;

  // IDLE and DONE entries are inert; only the M0..M5 rows drive operations.
  localparam desc_t ELEM_TBL [8] = '{
    '{dir_down: 1'b0, has_rd: 1'b0, has_wr: 1'b0, rd_bg: BG_ZERO, wr_bg: BG_ZERO}, // IDLE
    '{dir_down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_bg: BG_ZERO, wr_bg: BG_ZERO}, // M0 w0
    '{dir_down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_bg: BG_ZERO, wr_bg: BG_ONE }, // M1 up r0,w1
    '{dir_down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_bg: BG_ONE,  wr_bg: BG_ZERO}, // M2 up r1,w0
    '{dir_down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_bg: BG_ZERO, wr_bg: BG_ONE }, // M3 down r0,w1
    '{dir_down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_bg: BG_ONE,  wr_bg: BG_ZERO}, // M4 down r1,w0
    '{dir_down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_bg: BG_ZERO, wr_bg: BG_ZERO}, // M5 r0
    '{dir_down: 1'b0, has_rd: 1'b0, has_wr: 1'b0, rd_bg: BG_ZERO, wr_bg: BG_ZERO}  // DONE
  };

  // Element sequencing: IDLE -> M0 -> ... -> M5 -> DONE -> IDLE.
  function automatic state_t next_elem(input state_t s);
    case (s)
      ST_IDLE: return ST_M0;
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      ST_M5:   return ST_DONE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for the march elements. The direction is captured
// on load so that 'last' never depends combinationally on 'load'.
module march_addr_gen
  import march_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  logic dir_reg;

  // Load the element start address, or step one word in the held direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr    <= '0;
      dir_reg <= 1'b0;
    end else if (load) begin
      dir_reg <= dir;
      addr    <= dir ? TOP_ADDR : '0;
    end else if (step) begin
      addr <= dir_reg ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
    end
  end

  assign last = dir_reg ? (addr == '0) : (addr == TOP_ADDR);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller for a single-port array with combinational read.
// Optional failure logging (fail count, first failing address/data) is built
// only when MARCH_FAIL_LOG_EN is defined; otherwise a sticky flag drives pass.
module march_bist_ctrl
  import march_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              write_en,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_data
);

  state_t state_reg;
  logic   phase_reg;    // 0: read sub-step, 1: write sub-step of a two-op element

  state_t            nxt_elem;
  logic              cur_has_rd, cur_has_wr, nxt_has_rd, nxt_dir;
  logic [DATA_W-1:0] exp_word, wr_word, nxt_wr_word;
  logic              in_march, accept, is_read, op_end, miscompare;
  logic              last, load, step, fail_next;

  march_addr_gen #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .dir  (nxt_dir),
    .step (step),
    .addr (ram_addr),
    .last (last)
  );

  // Decode the current/next element and the operation ending this cycle.
  always_comb begin
    nxt_elem    = next_elem(state_reg);
    cur_has_rd  = ELEM_TBL[state_reg].has_rd;
    cur_has_wr  = ELEM_TBL[state_reg].has_wr;
    nxt_has_rd  = ELEM_TBL[nxt_elem].has_rd;
    nxt_dir     = ELEM_TBL[nxt_elem].dir_down;
    exp_word    = {DATA_W{&ELEM_TBL[state_reg].rd_bg}};
    wr_word     = {DATA_W{&ELEM_TBL[state_reg].wr_bg}};
    nxt_wr_word = {DATA_W{&ELEM_TBL[nxt_elem].wr_bg}};
    in_march    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    accept      = (state_reg == ST_IDLE) && start;
    is_read     = in_march && cur_has_rd && !(cur_has_wr && phase_reg);
    op_end      = in_march && (!(cur_has_rd && cur_has_wr) || phase_reg);
    miscompare  = is_read && (ram_rdata != exp_word);
    load        = accept || (op_end && last);
    step        = op_end && !last;
  end

  // Main sequencer: walks the elements and registers all array-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      phase_reg <= 1'b0;
      write_en  <= 1'b0;
      data_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done     <= 1'b0;
          write_en <= 1'b0;
          if (accept) begin
            state_reg <= nxt_elem;
            phase_reg <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            write_en  <= !nxt_has_rd;
            if (!nxt_has_rd) data_in <= nxt_wr_word;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          write_en  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          if (op_end && last) begin
            state_reg <= nxt_elem;
            phase_reg <= 1'b0;
            if (nxt_elem == ST_DONE) begin
              busy     <= 1'b0;
              done     <= 1'b1;
              write_en <= 1'b0;
              pass     <= !fail_next;
            end else begin
              write_en <= !nxt_has_rd;
              if (!nxt_has_rd) data_in <= nxt_wr_word;
            end
          end else if (op_end) begin
            phase_reg <= 1'b0;
            write_en  <= !cur_has_rd;
            if (!cur_has_rd) data_in <= wr_word;
          end else begin
            phase_reg <= 1'b1;
            write_en  <= 1'b1;
            data_in   <= wr_word;
          end
        end
      endcase
    end
  end

`ifdef MARCH_FAIL_LOG_EN
  // Saturating miscompare counter with capture of the first failing read.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      fail_count      <= 8'd0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (miscompare) begin
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
      if (fail_count == 8'd0) begin
        first_fail_addr <= ram_addr;
        first_fail_data <= ram_rdata;
      end
    end
  end

  assign fail_next = (fail_count != 8'd0) || miscompare;
`else
  logic fail_sticky_reg;

  // Single sticky flag: set by any miscompare, cleared on reset or new run.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      fail_sticky_reg <= 1'b0;
    end else if (miscompare) begin
      fail_sticky_reg <= 1'b1;
    end
  end

  assign fail_next       = fail_sticky_reg || miscompare;
  assign fail_count      = 8'd0;
  assign first_fail_addr = '0;
  assign first_fail_data = '0;
`endif

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Self-checking bench for march_bist_ctrl: table-driven fault scenarios with
// an operation-order scoreboard, plus hand sequences for reset, start
// re-pulse, held start and counter saturation (DEPTH=64 instance).
module tb_march_bist_ctrl;

`ifdef MARCH_FAIL_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1;
  logic [7:0] rdata0, din0, fc0, ffd0;
  logic [5:0] addr0, ffa0;
  logic       we0, busy0, done0, pass0;
  logic [7:0] rdata1, din1, fc1, ffd1;
  logic [5:0] addr1, ffa1;
  logic       we1, busy1, done1, pass1;

  int n_checks = 0;
  int n_fail   = 0;

  march_bist_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(32)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ram_rdata(rdata0),
    .ram_addr(addr0), .write_en(we0), .data_in(din0), .busy(busy0),
    .done(done0), .pass(pass0), .fail_count(fc0),
    .first_fail_addr(ffa0), .first_fail_data(ffd0)
  );

  march_bist_ctrl #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ram_rdata(rdata1),
    .ram_addr(addr1), .write_en(we1), .data_in(din1), .busy(busy1),
    .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_addr(ffa1), .first_fail_data(ffd1)
  );

  // Behavioural array for u0: 0 = fault-free, 1 = addr 5 bit 0 stuck-at-0,
  // 2 = every word reads 8'hAA.
  logic [7:0] mem0 [0:63];
  int mode = 0;

  always @(posedge clk) if (we0) mem0[addr0] <= din0;

  always_comb begin
    rdata0 = mem0[addr0];
    if (mode == 2) rdata0 = 8'hAA;
    else if (mode == 1 && addr0 == 6'd5) rdata0 = mem0[addr0] & 8'hFE;
  end

  assign rdata1 = 8'hAA;   // forced-fail model for the saturation run

  typedef struct {
    logic [5:0] addr;
    logic       we;
    logic [7:0] data;
  } op_t;
  op_t sb[$];

  typedef struct {
    string      name;
    int         mode;
    logic       exp_pass;
    logic [7:0] exp_fc;
    logic [5:0] exp_ffa;
    logic [7:0] exp_ffd;
  } vec_t;
  vec_t vecs[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int a, input bit w, input logic [7:0] d);
    op_t o;
    o.addr = 6'(a);
    o.we   = w;
    o.data = d;
    sb.push_back(o);
  endtask

  // Expected March C- operation stream for a 32-word run.
  task automatic gen_ops();
    sb.delete();
    for (int a = 0; a < 32; a++) push(a, 1'b1, 8'h00);
    for (int a = 0; a < 32; a++) begin push(a, 1'b0, 8'h00); push(a, 1'b1, 8'hFF); end
    for (int a = 0; a < 32; a++) begin push(a, 1'b0, 8'h00); push(a, 1'b1, 8'h00); end
    for (int a = 31; a >= 0; a--) begin push(a, 1'b0, 8'h00); push(a, 1'b1, 8'hFF); end
    for (int a = 31; a >= 0; a--) begin push(a, 1'b0, 8'h00); push(a, 1'b1, 8'h00); end
    for (int a = 0; a < 32; a++) push(a, 1'b0, 8'h00);
  endtask

  // One run on u0; returns at the cycle done is seen (or after a bound).
  task automatic run(input int m, input int pulse_at, input bit hold,
                     output int done_cyc, output int busy_cyc);
    op_t e;
    mode = m;
    gen_ops();
    start0 = 1'b1;
    tick();
    if (!hold) start0 = 1'b0;
    done_cyc = 0;
    busy_cyc = 0;
    for (int n = 1; n <= 700 && done_cyc == 0; n++) begin
      if (busy0) begin
        busy_cyc++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("op_order", {16'd0, addr0, we0, (we0 ? din0 : 8'h00)},
                {16'd0, e.addr, e.we, (e.we ? e.data : 8'h00)});
        end
      end
      if (done0) begin
        done_cyc = n;
      end else begin
        if (pulse_at != 0) start0 = (n == pulse_at);
        tick();
      end
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  int dc, bc, cyc;
  bit seen;

  initial begin
    for (int i = 0; i < 64; i++) mem0[i] = 8'h00;
    vecs[0] = '{"fault_free", 0, 1'b1, 8'h00, 6'd0, 8'h00};
    vecs[1] = '{"stuck_at0",  1, 1'b0, LOG_EN ? 8'h02 : 8'h00,
                LOG_EN ? 6'd5 : 6'd0, LOG_EN ? 8'hFE : 8'h00};
    vecs[2] = '{"all_aa",     2, 1'b0, LOG_EN ? 8'hA0 : 8'h00,
                6'd0, LOG_EN ? 8'hAA : 8'h00};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    tick(); tick(); tick();
    check("rst_addr", {26'd0, addr0}, 32'd0);
    check("rst_we_busy_done_pass", {28'd0, we0, busy0, done0, pass0}, 32'd0);
    check("rst_din", {24'd0, din0}, 32'd0);
    check("rst_log", {10'd0, fc0, ffa0, ffd0}, 32'd0);
    check("rst_u1", {we1, busy1, done1, pass1, fc1, addr1, din1, ffa1[3:0]}, 32'd0);
    check("rst_u1_ffd", {18'd0, ffa1, ffd1}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven fault scenarios.
    for (int i = 0; i < 3; i++) begin
      run(vecs[i].mode, 0, 1'b0, dc, bc);
      check({vecs[i].name, "_done_cycle"}, 32'(dc), 32'd321);
      check({vecs[i].name, "_busy_cycles"}, 32'(bc), 32'd320);
      check({vecs[i].name, "_busy_at_done"}, {31'd0, busy0}, 32'd0);
      check({vecs[i].name, "_pass"}, {31'd0, pass0}, {31'd0, vecs[i].exp_pass});
      check({vecs[i].name, "_fail_count"}, {24'd0, fc0}, {24'd0, vecs[i].exp_fc});
      check({vecs[i].name, "_ffa"}, {26'd0, ffa0}, {26'd0, vecs[i].exp_ffa});
      check({vecs[i].name, "_ffd"}, {24'd0, ffd0}, {24'd0, vecs[i].exp_ffd});
      $display("run %s: done at %0d busy %0d pass %0b fail_count %0h", vecs[i].name, dc, bc, pass0, fc0);
      tick();
      check({vecs[i].name, "_done_pulse"}, {31'd0, done0}, 32'd0);
      tick();
    end

    // start pulsed mid-run must be ignored.
    run(0, 50, 1'b0, dc, bc);
    check("restart_ignored_done_cycle", 32'(dc), 32'd321);
    check("restart_ignored_pass", {31'd0, pass0}, 32'd1);
    $display("run start_pulse_50: done at %0d pass %0b", dc, pass0);
    tick(); tick();

    // start held high: a new run begins on the IDLE cycle after DONE.
    run(0, 0, 1'b1, dc, bc);
    check("held_first_done", 32'(dc), 32'd321);
    tick();
    check("held_idle_busy", {30'd0, busy0, done0}, 32'd0);
    tick();
    check("held_restart", {24'd0, busy0, we0, addr0}, {24'd0, 1'b1, 1'b1, 6'd0});
    start0 = 1'b0;
    cyc = 1;
    while (!done0 && cyc < 400) begin tick(); cyc++; end
    check("held_second_done", 32'(cyc), 32'd321);
    check("held_second_pass", {31'd0, pass0}, 32'd1);
    $display("run held_start: second done after %0d cycles", cyc);
    tick(); tick();

    // Reset at cycle 100 of an all-failing run.
    mode = 2;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int n = 1; n < 100; n++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_we_busy_done", {29'd0, we0, busy0, done0}, 32'd0);
    check("midrst_fail_count", {24'd0, fc0}, 32'd0);
    check("midrst_addr_pass", {25'd0, addr0, pass0}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done0 || busy0) seen = 1'b1;
      tick();
    end
    check("midrst_no_done", {31'd0, seen}, 32'd0);
    run(0, 0, 1'b0, dc, bc);
    check("post_rst_done_cycle", 32'(dc), 32'd321);
    check("post_rst_pass", {31'd0, pass0}, 32'd1);
    $display("run after_reset: done at %0d pass %0b", dc, pass0);
    tick(); tick();

    // DEPTH=64 forced-fail run: 320 miscompares saturate the counter.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 1000) begin tick(); cyc++; end
    check("sat_done_cycle", 32'(cyc), 32'd641);
    check("sat_pass_we", {30'd0, pass1, we1}, 32'd0);
    check("sat_fail_count", {24'd0, fc1}, LOG_EN ? 32'hFF : 32'h0);
    $display("run depth64_sat: done at %0d fail_count %0h", cyc, fc1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
